// File: rtl/alu_pkg.sv
// Shared definitions for the wide-ALU sequencer and its 4-bit slice: opcodes, slice width, FSM states.
package alu_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NOT = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_CMP = 3'b110,
        OP_EQ  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // Arithmetic ops all run the slice as an adder and chain carry between nibbles.
    function automatic logic isArith(input op_t op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP) || (op == OP_EQ);
    endfunction

    function automatic logic isSubtract(input op_t op);
        return (op == OP_SUB) || (op == OP_CMP) || (op == OP_EQ);
    endfunction

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Command/response bus between the datapath controller (master) and the slice sequencer (slave).
interface alu_slice_sequencer_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    op_t              cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
    logic             rsp_overflow;
    logic             rsp_zero;
    logic             rsp_flag;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_flag
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_overflow, rsp_zero, rsp_flag
    );

endinterface

// File: rtl/alu_slice_sequencer.sv
// Runs one WIDTH-bit operation through an external 4-bit ALU slice, one nibble per cycle LSB first,
// chaining carry and assembling the wide result and flags for a response handshake.
module alu_slice_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alu_slice_sequencer_if.slave  bus,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [2:0]            alu_c,
    output logic                  alu_cin,
    input  logic [3:0]            alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_overflow
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    state_t           r_state;
    op_t              r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;

    logic             w_lastSlice;
    logic [WIDTH-1:0] w_finalResult;
    logic             w_finalZero;

    assign w_lastSlice = (r_idx == LAST_IDX);
    assign w_finalZero = (w_finalResult == '0);

    // Result as it will look once the current slice output is folded in; used on the last slice.
    always_comb begin
        w_finalResult = r_result;
        w_finalResult[{r_idx, 2'b00} +: SLICE_W] = alu_result;
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_c   = '0;
        alu_cin = 1'b0;
        if (r_state == ST_RUN) begin
            alu_a   = r_a[{r_idx, 2'b00} +: SLICE_W];
            alu_b   = r_b[{r_idx, 2'b00} +: SLICE_W];
            alu_c   = isArith(r_op) ? OP_ADD : r_op;
            alu_cin = r_carry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_op             <= OP_ADD;
            r_a              <= '0;
            r_b              <= '0;
            r_result         <= '0;
            r_idx            <= '0;
            r_carry          <= 1'b0;
            bus.cmd_ready    <= 1'b1;
            bus.rsp_valid    <= 1'b0;
            bus.rsp_result   <= '0;
            bus.rsp_carry    <= 1'b0;
            bus.rsp_overflow <= 1'b0;
            bus.rsp_zero     <= 1'b0;
            bus.rsp_flag     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        // Subtraction is A + ~B + 1, so B is inverted here and carry seeded with 1.
                        r_op          <= bus.cmd_op;
                        r_a           <= bus.cmd_a;
                        r_b           <= isSubtract(bus.cmd_op) ? ~bus.cmd_b : bus.cmd_b;
                        r_result      <= '0;
                        r_idx         <= '0;
                        r_carry       <= isSubtract(bus.cmd_op);
                        bus.cmd_ready <= 1'b0;
                        r_state       <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_result[{r_idx, 2'b00} +: SLICE_W] <= alu_result;
                    if (isArith(r_op)) begin
                        r_carry <= alu_carry;
                    end
                    r_idx <= r_idx + 1'b1;
                    if (w_lastSlice) begin
                        // CMP: signed less-than is sign of (A-B) corrected by overflow.
                        r_idx            <= '0;
                        bus.rsp_result   <= w_finalResult;
                        bus.rsp_carry    <= isArith(r_op) & alu_carry;
                        bus.rsp_overflow <= isArith(r_op) & alu_overflow;
                        bus.rsp_zero     <= w_finalZero;
                        bus.rsp_flag     <= (r_op == OP_CMP) ? (alu_result[3] ^ alu_overflow) :
                                            (r_op == OP_EQ)  ? w_finalZero : 1'b0;
                        bus.rsp_valid    <= 1'b1;
                        r_state          <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
